// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared fetch-unit state encoding and reset PC default
package ifu_fetch_pkg;
  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
endpackage

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: program counter with reset value, +4 step and word-aligned redirect load
module ifu_pc_reg import ifu_fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        load,
  input  logic [31:2] load_pc,
  output logic [31:0] pc
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else if (load) pc <= {load_pc, 2'b00};
    else if (inc) pc <= pc + 32'd4;
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with redirect and decode handoff
module ifu_fetch import ifu_fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [6:0]  id_opcode,
  output logic [4:0]  id_rd,
  output logic [2:0]  id_funct3,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [6:0]  id_funct7
);
  state_t state, state_n;
  logic kill, kill_n, inc, cap;
  logic [31:0] pc;
  logic unused_lo;
  assign unused_lo = ^redirect_pc[1:0];
  ifu_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .inc(inc), .load(redirect_valid),
    .load_pc(redirect_pc[31:2]), .pc(pc)
  );
  // a redirect always wins; kill marks an in-flight response that must be dropped
  always_comb begin
    state_n = state;
    kill_n = kill;
    inc = 1'b0;
    cap = 1'b0;
    case (state)
      S_REQ: if (imem_req_ready) begin
        state_n = S_WAIT;
        kill_n = redirect_valid;
      end
      S_WAIT: if (imem_rsp_valid) begin
        cap = !kill && !redirect_valid;
        state_n = cap ? S_HOLD : S_REQ;
        kill_n = 1'b0;
      end else if (redirect_valid) kill_n = 1'b1;
      S_HOLD: if (redirect_valid || id_ready) begin
        state_n = S_REQ;
        inc = !redirect_valid;
      end
      default: state_n = S_REQ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_REQ;
      kill <= 1'b0;
      id_inst <= 32'h0;
      id_pc <= RESET_PC;
    end else begin
      state <= state_n;
      kill <= kill_n;
      if (cap) begin
        id_inst <= imem_rsp_data;
        id_pc <= pc;
      end
    end
  assign imem_req_valid = rst_n && state == S_REQ;
  assign imem_req_addr = pc;
  assign imem_rsp_ready = state == S_WAIT;
  assign id_valid = state == S_HOLD;
  assign id_opcode = id_inst[6:0];
  assign id_rd = id_inst[11:7];
  assign id_funct3 = id_inst[14:12];
  assign id_rs1 = id_inst[19:15];
  assign id_rs2 = id_inst[24:20];
  assign id_funct7 = id_inst[31:25];
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: table-driven fetch vectors with scoreboard plus redirect/reset corner sequences
module tb_ifu_fetch;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0, imem_rsp_ready;
  logic [31:0] imem_req_addr, imem_rsp_data = 32'h0, redirect_pc = 32'h0, id_pc, id_inst;
  logic redirect_valid = 1'b0, id_valid, id_ready = 1'b0;
  logic [6:0] id_opcode, id_funct7;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic [2:0] id_funct3;
  always #5 clk = ~clk;
  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
    .id_opcode(id_opcode), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct7(id_funct7)
  );
  typedef struct {
    logic [31:0] inst;
    int req_dly, rsp_dly, hold;
    logic [6:0] opc;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [4:0] rs1, rs2;
    logic [6:0] f7;
  } vec_t;
  typedef struct {
    logic [31:0] pc, inst;
    logic [6:0] opc;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [4:0] rs1, rs2;
    logic [6:0] f7;
  } exp_t;
  vec_t vt[5];
  exp_t sb[$];
  exp_t e;
  int n = 0, bad = 0;
  logic [31:0] mpc;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  initial begin
    vt[0] = '{32'h002081B3, 0, 0, 0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00};
    vt[1] = '{32'h40208233, 0, 0, 0, 7'h33, 5'd4, 3'd0, 5'd1, 5'd2, 7'h20};
    vt[2] = '{32'hFFF00293, 0, 0, 0, 7'h13, 5'd5, 3'd0, 5'd0, 5'd31, 7'h7F};
    vt[3] = '{32'h00A00093, 5, 0, 4, 7'h13, 5'd1, 3'd0, 5'd0, 5'd10, 7'h00};
    vt[4] = '{32'h0062A023, 0, 2, 1, 7'h23, 5'd0, 3'd2, 5'd5, 5'd6, 7'h00};
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
    chk("rst_rsp_ready", {31'b0, imem_rsp_ready}, 0);
    chk("rst_id_valid", {31'b0, id_valid}, 0);
    chk("rst_id_inst", id_inst, 32'h0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("rel_req_valid", {31'b0, imem_req_valid}, 1);
    chk("rel_req_addr", imem_req_addr, 32'h8000_0000);
    mpc = 32'h8000_0000;
    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < vt[i].req_dly; d++) begin
        chk("stall_req_valid", {31'b0, imem_req_valid}, 1);
        chk("stall_req_addr", imem_req_addr, mpc);
        tick;
      end
      chk("req_valid", {31'b0, imem_req_valid}, 1);
      chk("req_addr", imem_req_addr, mpc);
      sb.push_back('{mpc, vt[i].inst, vt[i].opc, vt[i].rd, vt[i].f3, vt[i].rs1, vt[i].rs2, vt[i].f7});
      imem_req_ready = 1'b1;
      tick;
      imem_req_ready = 1'b0;
      for (int d = 0; d < vt[i].rsp_dly; d++) begin
        chk("wait_rsp_ready", {31'b0, imem_rsp_ready}, 1);
        chk("wait_id_valid", {31'b0, id_valid}, 0);
        tick;
      end
      chk("rsp_ready", {31'b0, imem_rsp_ready}, 1);
      imem_rsp_valid = 1'b1;
      imem_rsp_data = vt[i].inst;
      tick;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'h0;
      for (int d = 0; d < vt[i].hold; d++) begin
        chk("hold_id_valid", {31'b0, id_valid}, 1);
        chk("hold_id_inst", id_inst, vt[i].inst);
        chk("hold_no_req", {31'b0, imem_req_valid}, 0);
        tick;
      end
      chk("id_valid", {31'b0, id_valid}, 1);
      if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
      else begin
        e = sb.pop_front();
        chk("id_pc", id_pc, e.pc);
        chk("id_inst", id_inst, e.inst);
        chk("id_opcode", {25'b0, id_opcode}, {25'b0, e.opc});
        chk("id_rd", {27'b0, id_rd}, {27'b0, e.rd});
        chk("id_funct3", {29'b0, id_funct3}, {29'b0, e.f3});
        chk("id_rs1", {27'b0, id_rs1}, {27'b0, e.rs1});
        chk("id_rs2", {27'b0, id_rs2}, {27'b0, e.rs2});
        chk("id_funct7", {25'b0, id_funct7}, {25'b0, e.f7});
      end
      id_ready = 1'b1;
      tick;
      id_ready = 1'b0;
      mpc = mpc + 32'd4;
    end
    chk("after_vec_addr", imem_req_addr, mpc);
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    tick;
    redirect_valid = 1'b0;
    chk("kill_rsp_ready", {31'b0, imem_rsp_ready}, 1);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    tick;
    imem_rsp_valid = 1'b0;
    chk("wait_redir_id_valid", {31'b0, id_valid}, 0);
    chk("wait_redir_req_valid", {31'b0, imem_req_valid}, 1);
    chk("wait_redir_addr", imem_req_addr, 32'h8000_0100);
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0300;
    tick;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("req_redir_rsp_ready", {31'b0, imem_rsp_ready}, 1);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h1111_1111;
    tick;
    imem_rsp_valid = 1'b0;
    chk("req_redir_id_valid", {31'b0, id_valid}, 0);
    chk("req_redir_addr", imem_req_addr, 32'h8000_0300);
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h00A0_0093;
    tick;
    imem_rsp_valid = 1'b0;
    chk("hold2_id_valid", {31'b0, id_valid}, 1);
    chk("hold2_id_pc", id_pc, 32'h8000_0300);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    id_ready = 1'b1;
    tick;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    chk("hold_redir_id_valid", {31'b0, id_valid}, 0);
    chk("hold_redir_req_valid", {31'b0, imem_req_valid}, 1);
    chk("hold_redir_addr", imem_req_addr, 32'h8000_0200);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick;
    redirect_valid = 1'b0;
    chk("req_redir_stay", {31'b0, imem_req_valid}, 1);
    chk("req_redir_align", imem_req_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h0000_0013;
    tick;
    imem_rsp_valid = 1'b0;
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    id_ready = 1'b1;
    tick;
    id_ready = 1'b0;
    chk("wrap_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    tick;
    imem_req_ready = 1'b0;
    chk("pre_rst_rsp_ready", {31'b0, imem_rsp_ready}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 0);
    chk("mid_rst_rsp_ready", {31'b0, imem_rsp_ready}, 0);
    chk("mid_rst_id_valid", {31'b0, id_valid}, 0);
    chk("mid_rst_id_inst", id_inst, 32'h0);
    chk("mid_rst_addr", imem_req_addr, 32'h8000_0000);
    tick;
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hBAD0_BAD0;
    #1;
    chk("post_rst_req_valid", {31'b0, imem_req_valid}, 1);
    tick;
    imem_rsp_valid = 1'b0;
    chk("stale_id_valid", {31'b0, id_valid}, 0);
    chk("stale_req_valid", {31'b0, imem_req_valid}, 1);
    chk("stale_addr", imem_req_addr, 32'h8000_0000);
    chk("stale_rsp_ready", {31'b0, imem_rsp_ready}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit for the RV32E NPC; sits directly upstream of the decode/immediate-extension stage.
- Holds the PC and issues one instruction-memory read at a time over a valid/ready request/response pair.
- Buffers the returned word and presents it to decode with pre-split fields (rs1, rs2, rd, funct3, funct7, opcode) under a valid/ready handshake.
- Accepts PC redirects from execute for jumps and branches.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts request.
imem_req_addr  out  32  fetch address (word aligned).
imem_rsp_valid  in  1  read data valid.
imem_rsp_ready  out  1  IFU accepts response.
imem_rsp_data  in  32  instruction word.
redirect_valid  in  1  next-PC override from execute.
redirect_pc  in  32  override target.
id_valid  out  1  instruction available to decode.
id_ready  in  1  decode consumes instruction.
id_pc  out  32  PC of presented instruction.
id_inst  out  32  raw instruction.
id_opcode  out  7  id_inst[6:0].
id_rd  out  5  id_inst[11:7].
id_funct3  out  3  id_inst[14:12].
id_rs1  out  5  id_inst[19:15].
id_rs2  out  5  id_inst[24:20].
id_funct7  out  7  id_inst[31:25].

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc=RESET_PC, state=REQ, inst buffer=32'h0.
  - kill=0, id_valid=0, imem_rsp_ready=0.
  - imem_req_valid=0 while rst_n is low; it asserts combinationally from state REQ once rst_n is high.
- Single outstanding request. States:
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> WAIT.
  - WAIT: imem_rsp_ready=1. On imem_rsp_valid with kill=0: capture data into buffer, id_pc=pc -> HOLD. With kill=1: discard, clear kill -> REQ.
  - HOLD: id_valid=1, buffer and id_pc stable. On id_ready -> pc=pc+4 (mod 2^32, wraps silently) -> REQ.
- Latency: minimum 3 cycles from request issue to id_valid when memory is ready and responds the following cycle. Throughput is one instruction per 3 cycles with zero-wait memory.
- Field outputs are pure slices of the buffer. All id_* outputs are registered, stable while id_valid=1.
- Redirect has priority over all other events in the same cycle. The new PC is {redirect_pc[31:2],2'b00}; low bits are silently dropped.
  - REQ, no handshake this cycle: pc updated, stay REQ. The address may change while valid is asserted; this is the only permitted case.
  - REQ, handshake in same cycle: pc updated, kill=1, -> WAIT. The in-flight response is dropped.
  - WAIT, no response: pc updated, kill=1, stay WAIT. WAIT with response in same cycle: response discarded, pc updated, -> REQ.
  - HOLD: buffer discarded, id_valid=0 next cycle, pc updated, -> REQ. A simultaneous id_ready is ignored (instruction not consumed, no pc+4).
- Repeated redirects while kill=1: last target wins, kill stays 1.
- imem_rsp_valid outside WAIT is ignored.

Decomposition:
- Constants RESET_PC default, state encodings (REQ/WAIT/HOLD, 2-bit), and opcode field bit ranges go in shared defines.v beside `RegBus and `TYPE_BUS.
- One sub-module is natural: ifu_pc_reg (PC register with reset value, +4 increment, and aligned redirect load), instantiated once.

Test Plan:
- Reset release, memory always ready, 1-cycle response, id_ready=1: addresses 0x80000000, 0x80000004, 0x80000008 are issued; id_pc follows the same sequence with id_inst matching the memory data.
- imem_req_ready held low 5 cycles: imem_req_valid=1 and addr=0x80000000 stable throughout; no transition until ready.
- Return inst 0x00A00093 and hold id_ready=0 for 4 cycles: id_valid=1 the whole time with stable fields (opcode 0x13, rd 1, rs1 0, funct3 0, imm bits funct7 0, rs2 10); no new request issued.
- Redirect to 0x80000102 during WAIT, then the old response arrives: old data dropped, id_valid stays 0, next request addr=0x80000100.
- In HOLD, assert redirect_valid (target 0x80000200) and id_ready together: no pc+4, id_valid=0 next cycle, next request addr=0x80000200.
- Assert rst_n low mid-WAIT: outputs immediately return to reset values; after release, first request addr=RESET_PC and the late stale response is ignored.
